// File: rtl/shift_l_arb_pkg.sv
// Shared types and constants for the shift_l_arb arbitrated left shifter.
package shift_l_arb_pkg;

  // Response-side FSM: IDLE holds no result, RESP holds one valid result.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Width of each per-requester saturating transfer counter.
  localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/shift_l_nbit.sv
// Combinational logical left shifter: y = a << b.
// Bits shifted out are discarded and zeros are filled in from the right.
module shift_l_nbit #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SHIFT_WIDTH = 3
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [SHIFT_WIDTH-1:0] b,
  output logic [WIDTH-1:0]       y
);

  // Zero-filling logical shift, result truncated to WIDTH.
  always_comb begin
    y = a << b;
  end

endmodule

// File: rtl/shift_l_arb.sv
// shift_l_arb: NREQ requesters share one left shifter through a
// round-robin arbiter; the result is held in a registered response slot
// with valid/ready handshake and single-cycle back-to-back throughput.
// Optional feature: define SHIFT_L_ARB_STATS_EN to add grant_cnt, a
// 16-bit saturating transfer counter per requester.
module shift_l_arb
  import shift_l_arb_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SHIFT_WIDTH = 3,
  parameter int unsigned NREQ        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*WIDTH-1:0]       req_a,
  input  logic [NREQ*SHIFT_WIDTH-1:0] req_b,
  output logic [NREQ-1:0]             req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WIDTH-1:0]            rsp_y,
  output logic [$clog2(NREQ)-1:0]     rsp_id
`ifdef SHIFT_L_ARB_STATS_EN
  ,
  output logic [NREQ*STATS_W-1:0]     grant_cnt
`endif
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_t                 state;
  logic [IDW-1:0]         ptr;
  logic [IDW-1:0]         gidx;
  logic [IDW-1:0]         ptr_nxt;
  logic                   found;
  logic                   can_accept;
  logic [NREQ-1:0]        grant;
  logic                   xfer;
  int unsigned            idx;
  logic [WIDTH-1:0]       sel_a;
  logic [SHIFT_WIDTH-1:0] sel_b;
  logic [WIDTH-1:0]       shift_y;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && req_valid[IDW'(idx)]) begin
        found = 1'b1;
        gidx  = IDW'(idx);
      end
    end
  end

  // Grant only when the response slot is free or being drained this cycle.
  always_comb begin
    can_accept = (state == IDLE) || rsp_ready;
    grant      = '0;
    if (!rst && can_accept && found) begin
      grant[gidx] = 1'b1;
    end
    req_ready = grant;
    xfer      = |grant;
    ptr_nxt   = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
  end

  // Operand mux feeding the shared shifter from the granted requester.
  always_comb begin
    sel_a = WIDTH'(req_a >> (32'(gidx) * WIDTH));
    sel_b = SHIFT_WIDTH'(req_b >> (32'(gidx) * SHIFT_WIDTH));
  end

  shift_l_nbit #(
    .WIDTH       (WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_shift (
    .a (sel_a),
    .b (sel_b),
    .y (shift_y)
  );

  // Response FSM with registered result, id, valid and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_y     <= shift_y;
            rsp_id    <= gidx;
            ptr       <= ptr_nxt;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            if (xfer) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_y     <= shift_y;
              rsp_id    <= gidx;
              ptr       <= ptr_nxt;
            end else begin
              state     <= IDLE;
              rsp_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHIFT_L_ARB_STATS_EN
  logic [STATS_W-1:0] cnt_q [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
    // Per-requester transfer counter, saturating at all-ones.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[gi] <= '0;
      end else if (grant[gi] && (cnt_q[gi] != '1)) begin
        cnt_q[gi] <= cnt_q[gi] + 1'b1;
      end
    end

    assign grant_cnt[gi*STATS_W +: STATS_W] = cnt_q[gi];
  end
`else
  // No statistics counters in this build.
`endif

endmodule
